adc_trig_capture: RTL and testbench

Triggered snapshot buffer on one RFDC ADC AXI4-Stream output (8 samples/beat, 12-bit in 16-bit lanes). It sits directly downstream of the ADC tile, in parallel with the biquad/DAC path. It holds a circular history and freezes DEPTH beats around a threshold or forced trigger. Contents are read back through a simple address/data port on the same clock for later bridging to Wishbone.

---
 rtl/adc_capture_pkg.sv | 38 +++
 rtl/capture_sdp_ram.sv | 27 ++
 rtl/adc_trig_capture.sv | 205 ++++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and sample helpers for the triggered ADC snapshot buffer.
package adc_capture_pkg;

    // Widest beat the sample helper accepts; callers zero-extend narrower beats.
    localparam int MAX_LANES = 16;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

    // Sample k of a beat: top nbits of 16-bit lane k, sign-extended to 16 bits.
    function automatic logic signed [15:0] beat_sample(
        input logic [16*MAX_LANES-1:0] beat,
        input int                      k,
        input int                      nbits
    );
        logic [15:0] lane;
        lane = beat[16*k +: 16];
        return $signed(lane) >>> (16 - nbits);
    endfunction

    // |s| > thr without overflow: one extra bit lets -thr and s = -2^(n-1) both fit.
    function automatic logic over_thr(
        input logic signed [15:0] s,
        input logic        [15:0] thr
    );
        logic signed [16:0] s_x;
        logic signed [16:0] t_x;
        s_x = {s[15], s};
        t_x = {1'b0, thr};
        return (s_x > t_x) || (s_x < -t_x);
    endfunction

endpackage

// File: rtl/capture_sdp_ram.sv
// Simple dual-port snapshot memory: one write port, registered read address
// and registered read data (two-cycle read latency), no data-path reset.
module capture_sdp_ram #(
    parameter  int DEPTH = 1024,
    parameter  int DW    = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
        rdata   <= mem[raddr_q];
    end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered snapshot buffer on an RFDC ADC stream: keeps a circular history and
// freezes DEPTH beats around a threshold or software trigger for readback.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | nothing stored; waiting for arm
// PREFILL   | storing the pre-trigger history; triggers ignored
// WAIT_TRIG | storing continuously; watching for threshold or forced trigger
// POST      | storing the remainder of the window after the trigger beat
// DONE      | window frozen; buffer readable relative to capture start
module adc_trig_capture
    import adc_capture_pkg::*;
#(
    parameter  int NSAMP = 8,
    parameter  int NBITS = 12,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = $clog2(NSAMP),
    localparam int DW    = 16*NSAMP
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [DW-1:0]    s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             arm_i,
    input  logic             force_trig_i,
    input  logic [NBITS-2:0] threshold_i,
    input  logic [AW-1:0]    pretrig_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             trig_forced_o,
    output logic [SW-1:0]    trig_sample_o,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [DW-1:0]    rd_data_o
);

    cap_state_t state;
    cap_state_t state_nxt;

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          tmr;
    logic [AW-1:0]          pretrig_lat;
    logic [AW-1:0]          start_addr;
    logic [AW-1:0]          post_len;
    logic [NBITS-2:0]       thr_lat;
    logic [15:0]            thr_ext;
    logic                   force_pend;
    logic                   trig_forced;
    logic [SW-1:0]          trig_sample;
    logic                   tready_q;

    logic                   beat;
    logic                   ram_we;
    logic                   trig_beat;
    logic                   any_hit;
    logic [NSAMP-1:0]       hit;
    logic [SW-1:0]          hit_idx;
    logic [16*MAX_LANES-1:0] beat_ext;
    logic [DW-1:0]          ram_q;

    assign beat     = s_axis_tvalid;
    assign beat_ext = (16*MAX_LANES)'(s_axis_tdata);
    assign thr_ext  = 16'(thr_lat);
    assign post_len = AW'(DEPTH - 1) - pretrig_lat;

    // Scan downwards so the lowest over-threshold lane is the one reported.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int k = NSAMP - 1; k >= 0; k--) begin
            hit[k] = over_thr(beat_sample(beat_ext, k, NBITS), thr_ext);
            if (hit[k]) begin
                hit_idx = SW'(k);
            end
        end
    end

    assign any_hit   = |hit;
    assign trig_beat = (state == WAIT_TRIG) && beat && (force_pend || any_hit);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tmr counts down the remaining pre-trigger beats, then the remaining post beats.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (arm_i) begin
                    state_nxt = PREFILL;
                end
            end
            PREFILL: begin
                if ((tmr == '0) || (beat && (tmr == AW'(1)))) begin
                    state_nxt = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (trig_beat) begin
                    state_nxt = (post_len == '0) ? DONE : POST;
                end
            end
            POST: begin
                if (beat && (tmr == AW'(1))) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        ram_we = 1'b0;
        case (state)
            PREFILL: begin
                busy_o = 1'b1;
                ram_we = beat && (tmr != '0);
            end
            WAIT_TRIG, POST: begin
                busy_o = 1'b1;
                ram_we = beat;
            end
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            tmr         <= '0;
            pretrig_lat <= '0;
            thr_lat     <= '0;
            start_addr  <= '0;
            force_pend  <= 1'b0;
            trig_forced <= 1'b0;
            trig_sample <= '0;
            tready_q    <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (ram_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (arm_i) begin
                        tmr         <= pretrig_i;
                        pretrig_lat <= pretrig_i;
                        thr_lat     <= threshold_i;
                        force_pend  <= 1'b0;
                    end
                end
                PREFILL: begin
                    if (beat && (tmr != '0)) begin
                        tmr <= tmr - AW'(1);
                    end
                end
                WAIT_TRIG: begin
                    if (trig_beat) begin
                        start_addr  <= wr_ptr - pretrig_lat;
                        tmr         <= post_len;
                        trig_forced <= force_pend;
                        trig_sample <= force_pend ? '0 : hit_idx;
                        force_pend  <= 1'b0;
                    end else if (force_trig_i) begin
                        force_pend <= 1'b1;
                    end
                end
                POST: begin
                    if (beat) begin
                        tmr <= tmr - AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    capture_sdp_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (start_addr + rd_addr_i),
        .rdata (ram_q)
    );

    // The RAM output has no reset; hold the port at zero until the first clock after reset.
    assign rd_data_o     = tready_q ? ram_q : '0;
    assign s_axis_tready = tready_q;
    assign trig_forced_o = trig_forced;
    assign trig_sample_o = trig_sample;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Self-checking bench for adc_trig_capture with DEPTH=16: scenario sequences,
// a threshold vector table, and a readback scoreboard against logged beats.
module tb_adc_trig_capture;

    localparam int NSAMP = 8;
    localparam int NBITS = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = 16*NSAMP;

    logic             aclk          = 1'b0;
    logic             aresetn       = 1'b0;
    logic [W-1:0]     s_axis_tdata  = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             arm_i         = 1'b0;
    logic             force_trig_i  = 1'b0;
    logic [NBITS-2:0] threshold_i   = '0;
    logic [AW-1:0]    pretrig_i     = '0;
    logic             busy_o;
    logic             done_o;
    logic             trig_forced_o;
    logic [2:0]       trig_sample_o;
    logic [AW-1:0]    rd_addr_i     = '0;
    logic [W-1:0]     rd_data_o;

    adc_trig_capture #(
        .NSAMP (NSAMP),
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .arm_i         (arm_i),
        .force_trig_i  (force_trig_i),
        .threshold_i   (threshold_i),
        .pretrig_i     (pretrig_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .trig_forced_o (trig_forced_o),
        .trig_sample_o (trig_sample_o),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sent[$];
    logic [W-1:0] exp_q[$];

    typedef struct {
        int thr;
        int la;
        int va;
        int lb;
        int vb;
        bit trig;
        int lane;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] b);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        sent.push_back(b);
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic arm(input int pre, input int thr);
        arm_i       = 1'b1;
        pretrig_i   = AW'(pre);
        threshold_i = 11'(thr);
        sent.delete();
        step();
        arm_i = 1'b0;
    endtask

    // Lane holds the 12-bit sample in its top bits and junk in the low nibble.
    function automatic logic [W-1:0] put(input logic [W-1:0] b_in, input int k, input int v);
        logic [W-1:0] b;
        b = b_in;
        b[16*k +: 16] = {12'(v), 4'($urandom_range(15))};
        return b;
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < NSAMP; k++) begin
            b = put(b, k, v);
        end
        return b;
    endfunction

    function automatic bit beat_over(input logic [W-1:0] b, input int thr);
        int s;
        for (int k = 0; k < NSAMP; k++) begin
            s = int'(b[16*k+4 +: 12]);
            if (s >= 2048) s = s - 4096;
            if (s > thr || s < -thr) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected word for offset i is pushed when the address is driven and
    // popped when the two-cycle read result appears.
    task automatic readback(input string name, input int pre, input int trig);
        logic [W-1:0] e;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) begin
                rd_addr_i = AW'(i);
                exp_q.push_back(sent[trig - pre + i]);
            end
            step();
            if (i >= 1) begin
                e = exp_q.pop_front();
                chk($sformatf("%s_off%0d", name, i - 1), rd_data_o, e);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b;
        int need;
        int trig;
        int n;

        vecs[0] = '{100,  3,  101,  3,  101, 1'b1, 3};
        vecs[1] = '{100,  5,  100,  5,  100, 1'b0, 0};
        vecs[2] = '{100,  2, -100,  2, -100, 1'b0, 0};
        vecs[3] = '{100,  6, -101,  6, -101, 1'b1, 6};
        vecs[4] = '{0,    7,    1,  7,    1, 1'b1, 7};
        vecs[5] = '{0,    0,    0,  0,    0, 1'b0, 0};
        vecs[6] = '{2047, 4, -2048, 4, -2048, 1'b1, 4};
        vecs[7] = '{2047, 1, 2047,  1, 2047, 1'b0, 0};
        vecs[8] = '{50,   6,   60,  2,  -70, 1'b1, 2};
        vecs[9] = '{2047, 0, -2047, 0, -2047, 1'b0, 0};

        // reset values
        step();
        step();
        chk("rst_busy",   W'(busy_o),        W'(1'b0));
        chk("rst_done",   W'(done_o),        W'(1'b0));
        chk("rst_tready", W'(s_axis_tready), W'(1'b0));
        chk("rst_forced", W'(trig_forced_o), W'(1'b0));
        chk("rst_sample", W'(trig_sample_o), W'(1'b0));
        chk("rst_rdata",  rd_data_o,         '0);
        aresetn = 1'b1;
        step();
        chk("tready_up",  W'(s_axis_tready), W'(1'b1));

        // ramp with lane-3 spike at beat 20; arm during POST must be ignored
        arm(4, 100);
        for (int i = 0; i < 32; i++) begin
            b = fill(i);
            if (i == 20) b = put(b, 3, 200);
            if (i == 25) begin
                arm_i       = 1'b1;
                pretrig_i   = '0;
                threshold_i = '0;
            end
            send(b);
            arm_i = 1'b0;
            if (i == 30) begin
                chk("s1_busy30", W'(busy_o), W'(1'b1));
                chk("s1_done30", W'(done_o), W'(1'b0));
            end
        end
        chk("s1_done",   W'(done_o),        W'(1'b1));
        chk("s1_busy",   W'(busy_o),        W'(1'b0));
        chk("s1_forced", W'(trig_forced_o), W'(1'b0));
        chk("s1_sample", W'(trig_sample_o), W'(3));
        readback("s1", 4, 20);

        // forced trigger with no beats present waits for the next beat
        arm(0, 2047);
        step();
        step();
        force_trig_i = 1'b1;
        step();
        force_trig_i = 1'b0;
        repeat (5) step();
        chk("s2_wait_busy", W'(busy_o), W'(1'b1));
        chk("s2_wait_done", W'(done_o), W'(1'b0));
        for (int i = 0; i < DEPTH; i++) begin
            send(fill(i + 40));
            if (i == DEPTH - 2) chk("s2_done_early", W'(done_o), W'(1'b0));
        end
        chk("s2_done",   W'(done_o),        W'(1'b1));
        chk("s2_forced", W'(trig_forced_o), W'(1'b1));
        chk("s2_sample", W'(trig_sample_o), W'(0));
        readback("s2", 0, 0);

        // full pre-trigger: spike and force during PREFILL are ignored
        arm(15, 2047);
        for (int i = 0; i < 15; i++) begin
            b = fill(i + 1);
            if (i == 3) b = put(b, 5, -2048);
            if (i == 5) force_trig_i = 1'b1;
            send(b);
            force_trig_i = 1'b0;
        end
        chk("s3_busy_pre", W'(busy_o), W'(1'b1));
        chk("s3_done_pre", W'(done_o), W'(1'b0));
        send(put(fill(16), 0, -2048));
        chk("s3_done",   W'(done_o),        W'(1'b1));
        chk("s3_forced", W'(trig_forced_o), W'(1'b0));
        chk("s3_sample", W'(trig_sample_o), W'(0));
        readback("s3", 15, 15);

        // threshold table: non-triggering spikes fall back to a forced trigger
        for (int i = 0; i < 10; i++) begin
            arm(2, vecs[i].thr);
            send(fill(0));
            send(fill(0));
            send(put(put(fill(0), vecs[i].la, vecs[i].va), vecs[i].lb, vecs[i].vb));
            force_trig_i = 1'b1;
            step();
            force_trig_i = 1'b0;
            repeat (13) send(fill(0));
            chk($sformatf("v%0d_done13", i), W'(done_o), W'(vecs[i].trig));
            send(fill(0));
            chk($sformatf("v%0d_done", i),   W'(done_o),        W'(1'b1));
            chk($sformatf("v%0d_forced", i), W'(trig_forced_o), W'(!vecs[i].trig));
            chk($sformatf("v%0d_sample", i), W'(trig_sample_o), W'(vecs[i].trig ? vecs[i].lane : 0));
        end

        // reset in the middle of POST
        arm(4, 100);
        for (int i = 0; i < 8; i++) begin
            b = fill(i);
            if (i == 4) b = put(b, 1, -300);
            send(b);
        end
        chk("mr_busy_pre", W'(busy_o), W'(1'b1));
        aresetn = 1'b0;
        #2;
        chk("mr_busy",   W'(busy_o),        W'(1'b0));
        chk("mr_done",   W'(done_o),        W'(1'b0));
        chk("mr_tready", W'(s_axis_tready), W'(1'b0));
        chk("mr_forced", W'(trig_forced_o), W'(1'b0));
        chk("mr_rdata",  rd_data_o,         '0);
        step();
        aresetn = 1'b1;
        step();
        chk("mr_idle_busy", W'(busy_o),        W'(1'b0));
        chk("mr_tready_up", W'(s_axis_tready), W'(1'b1));

        // random valid gaps and random samples, spike at beat 20
        arm(6, 1500);
        need = -1;
        trig = -1;
        n    = 0;
        for (int cyc = 0; cyc < 600 && n != need; cyc++) begin
            if ($urandom_range(1) == 1) begin
                b = '0;
                for (int k = 0; k < NSAMP; k++) begin
                    b = put(b, k, int'($urandom_range(2800)) - 1400);
                end
                if (n == 20) begin
                    b = put(b, int'($urandom_range(7)), ($urandom_range(1) == 1) ? 1800 : -1800);
                end
                if (trig < 0 && n >= 6 && beat_over(b, 1500)) begin
                    trig = n;
                    need = n + DEPTH - 6;
                end
                send(b);
                n++;
            end else begin
                step();
            end
        end
        chk("rnd_budget", W'(n == need), W'(1'b1));
        chk("rnd_done",   W'(done_o),    W'(1'b1));
        if (trig >= 0) readback("rnd", 6, trig);

        // write pointer sits at 14 here, so the window wraps
        arm(5, 100);
        for (int i = 0; i < DEPTH; i++) begin
            b = fill(i + 50);
            if (i == 5) b = put(b, 2, 150);
            send(b);
            if (i == DEPTH - 2) chk("wrap_done_early", W'(done_o), W'(1'b0));
        end
        chk("wrap_done",   W'(done_o),        W'(1'b1));
        chk("wrap_sample", W'(trig_sample_o), W'(2));
        readback("wrap", 5, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
